// File: rtl/ddr2pe_ld_pkg.sv
// Shared loader/drain definitions: buffer geometry, FSM encodings and the
// (ch, pix, row) -> bank/address mapping used by both directions.
package ddr2pe_ld_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int BATCH  = 8;
  localparam int DDR_W  = BATCH / 2 * DATA_W;
  localparam int WORD_W = BATCH * DATA_W;
  localparam int NBANK  = 4;
  localparam int CNT_W  = 4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD_LO = 2'd1;
  localparam logic [1:0] S_LOAD_HI = 2'd2;
  localparam logic [1:0] S_LAST    = 2'd3;

  typedef struct packed {
    logic [CNT_W-1:0] ch;
    logic [CNT_W-1:0] pix;
    logic [CNT_W-1:0] row;
  } ld_pos_t;

  typedef struct packed {
    logic             single;
    logic [CNT_W-1:0] ch;
    logic [CNT_W-1:0] pix;
    logic [CNT_W-1:0] row;
  } ld_conf_t;

  function automatic logic [1:0] map_bank(input logic row_b0, input logic pix_b0);
    return {row_b0, pix_b0};
  endfunction

  // Rows above 3 alias onto the same strip addresses on purpose.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [CNT_W-1:0] ch,
                                                 input logic row_b1,
                                                 input logic [2:0] pix_hi);
    return {ch, row_b1, pix_hi};
  endfunction

  function automatic logic [NBANK-1:0] bank_onehot(input logic [1:0] bank);
    return NBANK'(1) << bank;
  endfunction

endpackage

// File: rtl/ddr2pe_ld_if.sv
// DDR read streams and activation-buffer write port seen by the loader.
interface ddr2pe_ld_if;
  import ddr2pe_ld_pkg::*;

  logic [DDR_W-1:0]  ddr1_data;
  logic              ddr1_valid;
  logic              ddr1_ready;
  logic [DDR_W-1:0]  ddr2_data;
  logic              ddr2_valid;
  logic              ddr2_ready;
  logic [ADDR_W-1:0] abuf_wr_addr;
  logic [WORD_W-1:0] abuf_wr_data;
  logic [NBANK-1:0]  abuf_wr_en;

  modport slave (
    input  ddr1_data, ddr1_valid, ddr2_data, ddr2_valid,
    output ddr1_ready, ddr2_ready, abuf_wr_addr, abuf_wr_data, abuf_wr_en
  );

  modport master (
    output ddr1_data, ddr1_valid, ddr2_data, ddr2_valid,
    input  ddr1_ready, ddr2_ready, abuf_wr_addr, abuf_wr_data, abuf_wr_en
  );

endinterface

// File: rtl/ddr2pe_ld_beat_pack.sv
// Joins two half-word DDR beats into one buffer word, either side by side
// (dual stream) or across two ddr1 beats via a held LO half (single stream).
module ddr2pe_ld_beat_pack
  import ddr2pe_ld_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_single,
  input  logic              i_busy,
  input  logic              i_hi_phase,
  input  logic [DDR_W-1:0]  i_ddr1_data,
  input  logic              i_ddr1_valid,
  input  logic [DDR_W-1:0]  i_ddr2_data,
  input  logic              i_ddr2_valid,
  output logic              o_ddr1_ready,
  output logic              o_ddr2_ready,
  output logic              o_lo_take,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_valid
);

  logic [DDR_W-1:0] r_lo;
  logic             w_hs1;

  // Dual stream: each side is only ready when its partner has data, so a
  // pair is always taken atomically.
  always_comb begin
    o_ddr1_ready = 1'b0;
    o_ddr2_ready = 1'b0;
    if (i_busy) begin
      if (i_single) begin
        o_ddr1_ready = 1'b1;
      end else begin
        o_ddr1_ready = i_ddr2_valid;
        o_ddr2_ready = i_ddr1_valid;
      end
    end
  end

  assign w_hs1        = i_ddr1_valid && o_ddr1_ready;
  assign o_lo_take    = i_single && !i_hi_phase && w_hs1;
  assign o_word_valid = i_single ? (w_hs1 && i_hi_phase) : (w_hs1 && i_ddr2_valid);
  assign o_word       = i_single ? {i_ddr1_data, r_lo} : {i_ddr2_data, i_ddr1_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lo <= '0;
    end else if (o_lo_take) begin
      r_lo <= i_ddr1_data;
    end
  end

endmodule

// File: rtl/ddr2pe_ld.sv
// DDR-to-PE loader: walks ch/pix/row, writing one packed word per handshake
// into the 4-bank activation buffer.
//   state     | meaning
//   IDLE      | done high, waiting for start
//   LOAD_LO   | waiting for a beat pair (dual) or the LO beat (single)
//   LOAD_HI   | single stream only: LO held, waiting for the HI beat
//   LAST      | final write on the bus, readies low
module ddr2pe_ld
  import ddr2pe_ld_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  output logic       o_done,
  input  logic [3:0] i_conf_layer_type,
  input  logic [3:0] i_conf_ch_num,
  input  logic [3:0] i_conf_pix_num,
  input  logic [3:0] i_conf_row_num,
  ddr2pe_ld_if.slave bus
);

  logic [1:0]        r_state;
  ld_conf_t          r_conf;
  ld_pos_t           r_pos;
  ld_pos_t           w_pos_nxt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [WORD_W-1:0] r_wr_data;
  logic [NBANK-1:0]  r_wr_en;

  logic              w_busy;
  logic              w_hi_phase;
  logic              w_lo_take;
  logic              w_word_valid;
  logic [WORD_W-1:0] w_word;
  logic              w_last;
  logic              w_unused_type;

  assign w_busy        = (r_state == S_LOAD_LO) || (r_state == S_LOAD_HI);
  assign w_hi_phase    = (r_state == S_LOAD_HI);
  assign w_unused_type = ^{i_conf_layer_type[3:2], i_conf_layer_type[0]};

  ddr2pe_ld_beat_pack u_pack (
    .clk          (clk),
    .rst          (rst),
    .i_single     (r_conf.single),
    .i_busy       (w_busy),
    .i_hi_phase   (w_hi_phase),
    .i_ddr1_data  (bus.ddr1_data),
    .i_ddr1_valid (bus.ddr1_valid),
    .i_ddr2_data  (bus.ddr2_data),
    .i_ddr2_valid (bus.ddr2_valid),
    .o_ddr1_ready (bus.ddr1_ready),
    .o_ddr2_ready (bus.ddr2_ready),
    .o_lo_take    (w_lo_take),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  assign w_last = (r_pos.ch == r_conf.ch) && (r_pos.pix == r_conf.pix) &&
                  (r_pos.row == r_conf.row);

  // ch innermost, then pix, then row; each wraps on equality with its conf.
  always_comb begin
    w_pos_nxt = r_pos;
    if (r_pos.ch != r_conf.ch) begin
      w_pos_nxt.ch = r_pos.ch + 4'd1;
    end else begin
      w_pos_nxt.ch = '0;
      if (r_pos.pix != r_conf.pix) begin
        w_pos_nxt.pix = r_pos.pix + 4'd1;
      end else begin
        w_pos_nxt.pix = '0;
        w_pos_nxt.row = (r_pos.row != r_conf.row) ? (r_pos.row + 4'd1) : 4'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_conf    <= '0;
      r_pos     <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= '0;
    end else begin
      r_wr_en <= '0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_conf.single <= i_conf_layer_type[1];
            r_conf.ch     <= i_conf_ch_num;
            r_conf.pix    <= i_conf_pix_num;
            r_conf.row    <= i_conf_row_num;
            r_pos         <= '0;
            r_state       <= S_LOAD_LO;
          end
        end
        S_LOAD_LO, S_LOAD_HI: begin
          if (w_lo_take) begin
            r_state <= S_LOAD_HI;
          end
          if (w_word_valid) begin
            r_wr_en   <= bank_onehot(map_bank(r_pos.row[0], r_pos.pix[0]));
            r_wr_addr <= map_addr(r_pos.ch, r_pos.row[1], r_pos.pix[3:1]);
            r_wr_data <= w_word;
            r_pos     <= w_pos_nxt;
            r_state   <= w_last ? S_LAST : S_LOAD_LO;
          end
        end
        S_LAST: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_done           = (r_state == S_IDLE);
  assign bus.abuf_wr_en   = r_wr_en;
  assign bus.abuf_wr_addr = r_wr_addr;
  assign bus.abuf_wr_data = r_wr_data;

endmodule

// File: tb/tb_ddr2pe_ld.sv
// Scoreboard bench for ddr2pe_ld: drivers push expected writes from a
// nested-loop model; a monitor pops and compares each buffer write.
module tb_ddr2pe_ld;
  import ddr2pe_ld_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       done;
  logic [3:0] c_type = '0, c_ch = '0, c_pix = '0, c_row = '0;

  ddr2pe_ld_if bus ();

  ddr2pe_ld dut (
    .clk               (clk),
    .rst               (rst),
    .i_start           (start),
    .o_done            (done),
    .i_conf_layer_type (c_type),
    .i_conf_ch_num     (c_ch),
    .i_conf_pix_num    (c_pix),
    .i_conf_row_num    (c_row),
    .bus               (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;

  typedef struct {
    logic [7:0]   addr;
    logic [3:0]   en;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [7:0] addr;
    logic [3:0] en;
  } pos_t;

  exp_t exp_q[$];
  pos_t pos_q[$];

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst && bus.abuf_wr_en != 4'd0) begin
        if (exp_q.size() == 0) begin
          check("spurious_write_en", 128'(bus.abuf_wr_en), 128'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_addr", 128'(bus.abuf_wr_addr), 128'(e.addr));
          check("wr_en",   128'(bus.abuf_wr_en),   128'(e.en));
          check("wr_data", bus.abuf_wr_data,       e.data);
          check("wr_cycle", 128'(cyc),             128'(e.cyc));
          n_writes++;
        end
      end
    end
  endtask

  // Reference order: row outer, pix middle, ch inner; bank from parities.
  task automatic plan_load(input int ch, input int pix, input int row);
    pos_t p;
    for (int r = 0; r <= row; r++)
      for (int q = 0; q <= pix; q++)
        for (int c = 0; c <= ch; c++) begin
          p.addr = 8'(c * 16 + ((r / 2) % 2) * 8 + q / 2);
          p.en   = 4'(1 << ((r % 2) * 2 + (q % 2)));
          pos_q.push_back(p);
        end
  endtask

  task automatic hs_push(input logic [127:0] word);
    pos_t p;
    exp_t e;
    check("handshake_expected", 128'(pos_q.size() != 0), 128'(1));
    if (pos_q.size() != 0) begin
      p = pos_q.pop_front();
      e.addr = p.addr;
      e.en   = p.en;
      e.data = word;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input logic [3:0] ty, input logic [3:0] ch,
                          input logic [3:0] pix, input logic [3:0] row);
    check("done_before_start", 128'(done), 128'(1));
    c_type = ty; c_ch = ch; c_pix = pix; c_row = row;
    start = 1'b1;
    plan_load(int'(ch), int'(pix), int'(row));
    @(posedge clk); #1;
    start = 1'b0;
    c_type = 4'($urandom); c_ch = 4'($urandom); c_pix = 4'($urandom); c_row = 4'($urandom);
    @(negedge clk);
    check("done_low_after_start", 128'(done), 128'(0));
    @(posedge clk); #1;
  endtask

  task automatic send_dual(input logic [63:0] lo, input logic [63:0] hi,
                           input int g1, input int g2);
    int c = 0;
    bit hs = 0;
    bus.ddr1_data = lo;
    bus.ddr2_data = hi;
    while (!hs && c < 100) begin
      bus.ddr1_valid = (c >= g1);
      bus.ddr2_valid = (c >= g2);
      @(negedge clk);
      if (!bus.ddr2_valid) check("ddr1_ready_gated", 128'(bus.ddr1_ready), 128'(0));
      if (!bus.ddr1_valid) check("ddr2_ready_gated", 128'(bus.ddr2_ready), 128'(0));
      if (bus.ddr1_valid && bus.ddr2_valid) begin
        hs = 1;
        check("dual_readies", 128'({bus.ddr1_ready, bus.ddr2_ready}), 128'(2'b11));
        hs_push({hi, lo});
      end
      @(posedge clk); #1;
      c++;
    end
    check("dual_handshake_done", 128'(hs), 128'(1));
    bus.ddr1_valid = 1'b0;
    bus.ddr2_valid = 1'b0;
  endtask

  task automatic single_beat(input logic [63:0] d, input bit is_hi,
                             input logic [127:0] word);
    int c = 0;
    bit hs = 0;
    bus.ddr1_data  = d;
    bus.ddr1_valid = 1'b1;
    bus.ddr2_valid = 1'b1;
    while (!hs && c < 50) begin
      @(negedge clk);
      check("ddr2_ready_single", 128'(bus.ddr2_ready), 128'(0));
      if (bus.ddr1_ready) begin
        hs = 1;
        if (is_hi) hs_push(word);
      end
      @(posedge clk); #1;
      c++;
    end
    check("single_beat_accepted", 128'(hs), 128'(1));
    bus.ddr1_valid = 1'b0;
    bus.ddr2_valid = 1'b0;
  endtask

  task automatic send_single(input logic [63:0] lo, input logic [63:0] hi, input int gap);
    single_beat(lo, 1'b0, '0);
    repeat (gap) begin
      bus.ddr1_data = ~lo;
      @(negedge clk);
      check("ddr2_ready_gap", 128'(bus.ddr2_ready), 128'(0));
      @(posedge clk); #1;
    end
    single_beat(hi, 1'b1, {hi, lo});
  endtask

  task automatic finish_load();
    bus.ddr1_valid = 1'b1;
    bus.ddr2_valid = 1'b1;
    @(negedge clk);
    check("ready1_after_last", 128'(bus.ddr1_ready), 128'(0));
    check("ready2_after_last", 128'(bus.ddr2_ready), 128'(0));
    check("done_during_last",  128'(done), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("done_two_after_last", 128'(done), 128'(1));
    check("ready1_idle", 128'(bus.ddr1_ready), 128'(0));
    check("writes_outstanding", 128'(exp_q.size()), 128'(0));
    check("handshakes_missing", 128'(pos_q.size()), 128'(0));
    bus.ddr1_valid = 1'b0;
    bus.ddr2_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"},   128'(done), 128'(1));
    check({tag, "_ready1"}, 128'(bus.ddr1_ready), 128'(0));
    check({tag, "_ready2"}, 128'(bus.ddr2_ready), 128'(0));
    check({tag, "_wr_en"},  128'(bus.abuf_wr_en), 128'(0));
    check({tag, "_addr"},   128'(bus.abuf_wr_addr), 128'(0));
    check({tag, "_data"},   bus.abuf_wr_data, 128'(0));
  endtask

  initial begin
    int w0;
    bus.ddr1_data = '0; bus.ddr1_valid = 1'b0;
    bus.ddr2_data = '0; bus.ddr2_valid = 1'b0;
    fork
      monitor();
    join_none
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Dual 1/1/1, streams always valid: 8 back-to-back writes.
    do_start(4'd0, 4'd1, 4'd1, 4'd1);
    for (int i = 0; i < 8; i++) send_dual({$urandom, $urandom}, {$urandom, $urandom}, 0, 0);
    finish_load();

    // Single, all-zero conf, 3 idle cycles between LO and HI.
    do_start(4'd2, 4'd0, 4'd0, 4'd0);
    send_single(64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 3);
    finish_load();

    // Dual with ddr2 lagging ddr1 by 5 cycles, then the reverse.
    do_start(4'd0, 4'd0, 4'd1, 4'd0);
    send_dual({$urandom, $urandom}, {$urandom, $urandom}, 0, 5);
    send_dual({$urandom, $urandom}, {$urandom, $urandom}, 3, 1);
    finish_load();

    // start pulsed mid-load must be ignored.
    do_start(4'd0, 4'd3, 4'd0, 4'd0);
    send_dual({$urandom, $urandom}, {$urandom, $urandom}, 0, 0);
    send_dual({$urandom, $urandom}, {$urandom, $urandom}, 1, 0);
    c_ch = 4'd0; c_pix = 4'd0; c_row = 4'd0; c_type = 4'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("done_after_ignored_start", 128'(done), 128'(0));
    @(posedge clk); #1;
    send_dual({$urandom, $urandom}, {$urandom, $urandom}, 0, 2);
    send_dual({$urandom, $urandom}, {$urandom, $urandom}, 0, 0);
    finish_load();

    // Full 15/15/15 dual sweep with random valid gaps.
    w0 = n_writes;
    do_start(4'd0, 4'd15, 4'd15, 4'd15);
    for (int i = 0; i < 4096; i++)
      send_dual({$urandom, $urandom}, {$urandom, $urandom},
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    finish_load();
    check("sweep_write_count", 128'(n_writes - w0), 128'(4096));

    // Reset after the LO beat of write 3 in single mode.
    do_start(4'd2, 4'd3, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) send_single({$urandom, $urandom}, {$urandom, $urandom}, 0);
    single_beat({$urandom, $urandom}, 1'b0, '0);
    bus.ddr1_data  = {$urandom, $urandom};
    bus.ddr1_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midload_reset");
    check("writes_before_reset", 128'(exp_q.size()), 128'(0));
    pos_q.delete();
    bus.ddr1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_start(4'd2, 4'd0, 4'd0, 4'd0);
    send_single(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1);
    finish_load();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
